// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-outstanding Wishbone classic initiator with command/response channels
module wb_cmd_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    // Last BUS cycle before giving up; STB is then high for exactly TIMEOUT cycles.
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_SAT  = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          cyc;

    // CYC and STB are one register so they can never disagree.
    assign wbm_cyc_o   = cyc;
    assign wbm_stb_o   = cyc;
    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);

    // Command accept, bus cycle with ACK timeout, and response hold.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state       <= IDLE;
            timer       <= '0;
            cyc         <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= 32'h0;
            wbm_dat_o   <= 32'h0;
            wbm_sel_o   <= 4'h0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= 32'h0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        wbm_we_o  <= cmd_we_i;
                        wbm_adr_o <= cmd_adr_i;
                        wbm_dat_o <= cmd_dat_i;
                        wbm_sel_o <= cmd_sel_i;
                        cyc       <= 1'b1;
                        timer     <= '0;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    // ACK is checked first so a last-cycle ACK is not reported as a timeout.
                    if (wbm_ack_i) begin
                        cyc         <= 1'b0;
                        rsp_dat_o   <= wbm_we_o ? 32'h0 : wbm_dat_i;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else if (timer == T_LAST) begin
                        cyc         <= 1'b0;
                        rsp_dat_o   <= 32'h0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else if (timer != T_SAT) begin
                        timer <= timer + TW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - self-checking bench for wb_cmd_master
module tb_wb_cmd_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_adr_i = 32'h0;
    logic [31:0] cmd_dat_i = 32'h0;
    logic [3:0]  cmd_sel_i = 4'h0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        busy_o;

    always #5 clk = ~clk;

    wb_cmd_master #(.TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_we_o(wbm_we_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_sel_o(wbm_sel_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
        .busy_o(busy_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          ack_at;   // STB cycle (1-based) in which the slave ACKs; 0 = never
        logic [31:0] rdata;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_stb;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    rsp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic e);
        rsp_t r;
        r.dat = d;
        r.err = e;
        sbq.push_back(r);
    endtask

    task automatic pop_cmp(input string name);
        rsp_t r;
        if (sbq.size() == 0) begin
            check({name, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            r = sbq.pop_front();
            check({name, "_rsp_dat"}, rsp_dat_o, r.dat);
            check({name, "_rsp_err"}, {31'd0, rsp_err_o}, {31'd0, r.err});
        end
    endtask

    // Present a command and hold it until the edge at which it is accepted.
    task automatic drive_cmd(input vec_t v, input string name);
        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_we_i    = v.we;
        cmd_adr_i   = v.adr;
        cmd_dat_i   = v.dat;
        cmd_sel_i   = v.sel;
        for (int t = 0; t < 50 && !cmd_ready_o; t++) @(negedge clk);
        check({name, "_cmd_ready"}, {31'd0, cmd_ready_o}, 32'd1);
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic handshake(input string name);
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1 rsp_ready_i = 1'b0;
        @(negedge clk);
        check({name, "_after_hs"}, {29'd0, rsp_valid_o, cmd_ready_o, wbm_stb_o}, 32'b010);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int stb_n  = 0;
        bit done   = 0;
        bit stable = 1;
        drive_cmd(v, name);
        push_exp(v.exp_dat, v.exp_err);
        for (int t = 0; t < TO + 4 && !done; t++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                done      = 1;
                wbm_ack_i = 1'b0;
            end else begin
                if (!wbm_stb_o || wbm_cyc_o !== wbm_stb_o || wbm_we_o !== v.we ||
                    wbm_adr_o !== v.adr || wbm_dat_o !== v.dat || wbm_sel_o !== v.sel)
                    stable = 0;
                if (wbm_stb_o) stb_n++;
                wbm_ack_i = (stb_n == v.ack_at);
                wbm_dat_i = v.rdata;
            end
        end
        check({name, "_rsp_seen"}, {31'd0, done}, 32'd1);
        check({name, "_bus_stable"}, {31'd0, stable}, 32'd1);
        check({name, "_stb_cycles"}, stb_n, v.exp_stb);
        check({name, "_stb_off"}, {31'd0, wbm_cyc_o | wbm_stb_o}, 32'd0);
        pop_cmp(name);
        handshake(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        vec_t bp_a, bp_b, rst_c;
        bit   ok;

        vt[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 3, 32'h1111_2222, 32'h0,         1'b0, 3};
        vt[1] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1};
        vt[2] = '{1'b0, 32'h3000_0020, 32'h0,         4'hF, 0, 32'h7777_7777, 32'h0,         1'b1, 4};
        vt[3] = '{1'b0, 32'h3000_0024, 32'h0,         4'hF, 4, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 4};
        vt[4] = '{1'b1, 32'h3000_0028, 32'h1234_5678, 4'h3, 0, 32'h9999_0000, 32'h0,         1'b1, 4};
        vt[5] = '{1'b0, 32'h3000_002C, 32'h0,         4'h6, 2, 32'h0123_4567, 32'h0123_4567, 1'b0, 2};

        // Reset values
        #12;
        check("rst_outs_zero", {31'd0, |{wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
              wbm_sel_o, rsp_valid_o, rsp_dat_o, rsp_err_o, busy_o}}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("v%0d", i));

        // Response backpressure with a pending second command and stray ACKs
        bp_a = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 1, 32'h5555_AAAA, 32'h5555_AAAA, 1'b0, 1};
        bp_b = '{1'b1, 32'h3000_0008, 32'h0BAD_F00D, 4'hC, 1, 32'h0,         32'h0,         1'b0, 1};
        drive_cmd(bp_a, "bp_a");
        push_exp(bp_a.exp_dat, bp_a.exp_err);
        @(negedge clk);
        wbm_ack_i = 1'b1;
        wbm_dat_i = bp_a.rdata;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        check("bp_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = bp_b.we;
        cmd_adr_i   = bp_b.adr;
        cmd_dat_i   = bp_b.dat;
        cmd_sel_i   = bp_b.sel;
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid_o || rsp_dat_o !== 32'h5555_AAAA || rsp_err_o || cmd_ready_o || wbm_stb_o)
                ok = 0;
            wbm_ack_i = i[0];
            wbm_dat_i = $urandom;
        end
        check("bp_held_stable", {31'd0, ok}, 32'd1);
        @(negedge clk);
        wbm_ack_i = 1'b0;
        pop_cmp("bp_a");
        handshake("bp_a");
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
        push_exp(bp_b.exp_dat, bp_b.exp_err);
        @(negedge clk);
        check("bp_b_issued", {wbm_stb_o, wbm_we_o, wbm_sel_o, 26'd0}, {1'b1, 1'b1, 4'hC, 26'd0});
        check("bp_b_adr", wbm_adr_o, 32'h3000_0008);
        check("bp_b_dat", wbm_dat_o, 32'h0BAD_F00D);
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        check("bp_b_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        pop_cmp("bp_b");
        handshake("bp_b");

        // Reset in the 2nd STB cycle: CYC/STB drop without a clock edge, no response
        rst_c = '{1'b0, 32'h3000_0030, 32'h0, 4'hF, 0, 32'h0, 32'h0, 1'b1, 4};
        drive_cmd(rst_c, "rst_c");
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_stb_before", {31'd0, wbm_stb_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_stb_async", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        check("rst_mid_outs_zero", {31'd0, |{wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
              rsp_valid_o, rsp_dat_o, rsp_err_o, busy_o}}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid_o || busy_o || !cmd_ready_o) ok = 0;
        end
        check("rst_mid_no_rsp", {31'd0, ok}, 32'd1);
        run_vec(vt[1], "post_rst");
        run_vec(vt[2], "post_rst_to");

        check("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
